// File: rtl/dmux1t8_32_buf.sv
// dmux1t8_32_buf: registered 1-to-8 demultiplexer for WIDTH-bit words.
// An incoming word is steered into one of eight holding registers. The target
// is the explicit select `s` or, when `seq` is set, the round-robin pointer
// `ptr`. Each holding register has a valid flag that the consumer clears with
// its per-channel acknowledge.
//
// Handshake: a word transfers on a rising edge where i_valid && i_ready.
// i_ready depends only on the current target's valid flag and its ack:
// i_ready = ~o_valid[t] | o_ack[t]. The producer holds i, s and seq stable
// while i_valid is high and i_ready is low. i_valid never feeds i_ready.
// A consumer ack in the same edge as a write to that channel loses to the
// write, so the channel stays valid and holds the new word.
//
// The block has no FSM. All sequencing state is visible on the ports:
// `ptr` carries the pointer and `o_valid` carries the occupancy flags.
module dmux1t8_32_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i,
    input  logic [2:0]       s,
    input  logic             seq,
    input  logic             i_valid,
    output logic             i_ready,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic [WIDTH-1:0] o4,
    output logic [WIDTH-1:0] o5,
    output logic [WIDTH-1:0] o6,
    output logic [WIDTH-1:0] o7,
    output logic [7:0]       o_valid,
    input  logic [7:0]       o_ack,
    output logic [2:0]       ptr,
    output logic             all_full
);

    logic [WIDTH-1:0] data_q [8];
    logic [2:0]       tgt;
    logic             accept;
    logic [7:0]       wr_mask;

    // Pick the target channel, decide readiness and build a one-hot write mask.
    always_comb begin
        tgt     = seq ? ptr : s;
        i_ready = ~o_valid[tgt] | o_ack[tgt];
        accept  = i_valid & i_ready;
        wr_mask = accept ? (8'd1 << tgt) : 8'd0;
    end

    // Holding registers: a register is loaded only when written. An ack does not clear it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 8; n++) data_q[n] <= '0;
        end else begin
            for (int n = 0; n < 8; n++) begin
                if (wr_mask[n]) data_q[n] <= i;
            end
        end
    end

    // Valid flags: an ack clears its flag and a write sets it. The write wins on a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) o_valid <= 8'h00;
        else     o_valid <= (o_valid & ~o_ack) | wr_mask;
    end

    // Round-robin pointer: it advances only on accepts made in sequential mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                ptr <= 3'd0;
        else if (accept && seq) ptr <= ptr + 3'd1;
    end

    assign all_full = &o_valid;
    assign o0 = data_q[0];
    assign o1 = data_q[1];
    assign o2 = data_q[2];
    assign o3 = data_q[3];
    assign o4 = data_q[4];
    assign o5 = data_q[5];
    assign o6 = data_q[6];
    assign o7 = data_q[7];

endmodule

// File: tb/tb_dmux1t8_32_buf.sv
// Bench for dmux1t8_32_buf. A behavioural model (arrays and a pointer) is
// updated whenever stimulus is issued. The expected post-edge state is pushed
// into exp_q, and a monitor pops and compares it after every clock edge.
module tb_dmux1t8_32_buf;

    localparam int SW = 8 * 32 + 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i;
    logic [2:0]  s;
    logic        seq;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] o0, o1, o2, o3, o4, o5, o6, o7;
    logic [7:0]  o_valid;
    logic [7:0]  o_ack;
    logic [2:0]  ptr;
    logic        all_full;

    int n_checks = 0;
    int n_fail   = 0;

    logic [SW-1:0] exp_q [$];

    // behavioural model state
    logic [31:0] m_data [8];
    logic [7:0]  m_vld;
    int          m_ptr;
    logic        last_acc;

    dmux1t8_32_buf #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .i(i), .s(s), .seq(seq), .i_valid(i_valid),
        .i_ready(i_ready), .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4),
        .o5(o5), .o6(o6), .o7(o7), .o_valid(o_valid), .o_ack(o_ack),
        .ptr(ptr), .all_full(all_full)
    );

    // clock
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_data(input int n);
        case (n)
            0: return o0;
            1: return o1;
            2: return o2;
            3: return o3;
            4: return o4;
            5: return o5;
            6: return o6;
            default: return o7;
        endcase
    endfunction

    function automatic logic [SW-1:0] dut_snap();
        return {o7, o6, o5, o4, o3, o2, o1, o0, o_valid, ptr, all_full};
    endfunction

    function automatic logic [SW-1:0] model_snap();
        logic [SW-1:0] v;
        v = '0;
        for (int n = 0; n < 8; n++) v[12 + n*32 +: 32] = m_data[n];
        v[11:4] = m_vld;
        v[3:1]  = m_ptr[2:0];
        v[0]    = &m_vld;
        return v;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 8; n++) m_data[n] = 32'h0;
        m_vld = 8'h00;
        m_ptr = 0;
    endtask

    // monitor / scoreboard: after each edge, compare the state against the oldest expectation
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            logic [SW-1:0] e;
            logic [SW-1:0] a;
            e = exp_q.pop_front();
            a = dut_snap();
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL state_after_edge: got %h, required %h at %0t", a, e, $time);
            end
        end
    end

    // driver: offer one cycle of stimulus, check i_ready, advance the model and queue the expectation
    task automatic step(input logic iv, input logic [2:0] sel, input logic sq,
                        input logic [31:0] d, input logic [7:0] ack);
        int   t;
        logic rdy;
        i_valid = iv; s = sel; seq = sq; i = d; o_ack = ack;
        #1;
        t   = sq ? m_ptr : int'(sel);
        rdy = !m_vld[t] || ack[t];
        chk("i_ready", {31'b0, i_ready}, {31'b0, rdy});
        for (int n = 0; n < 8; n++) if (ack[n]) m_vld[n] = 1'b0;
        last_acc = iv && rdy;
        if (last_acc) begin
            m_data[t] = d;
            m_vld[t]  = 1'b1;
            if (sq) m_ptr = (m_ptr + 1) % 8;
        end
        exp_q.push_back(model_snap());
        @(posedge clk);
        #2;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_o_valid"}, {24'b0, o_valid}, 32'h0);
        chk({tag, "_ptr"}, {29'b0, ptr}, 32'h0);
        chk({tag, "_i_ready"}, {31'b0, i_ready}, 32'h1);
        chk({tag, "_all_full"}, {31'b0, all_full}, 32'h0);
        for (int n = 0; n < 8; n++) chk({tag, "_data"}, dut_data(n), 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1; i = 32'hFFFF_FFFF; i_valid = 1'b1; s = 3'd0; seq = 1'b0; o_ack = 8'h00;
        model_reset();
        #1;
        check_cleared("reset");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0; i_valid = 1'b0;
        #1;
        check_cleared("reset_release");
    endtask

    initial begin
        logic        hold;
        logic        iv;
        logic [31:0] hd;
        logic [2:0]  hs;
        logic        hq;

        // reset with a pending write that must be ignored
        do_reset();

        // directed writes s = 0..7 carrying i = 1..8
        for (int n = 0; n < 8; n++) step(1'b1, 3'(n), 1'b0, 32'(n + 1), 8'h00);
        chk("dir_o_valid", {24'b0, o_valid}, 32'hFF);
        chk("dir_all_full", {31'b0, all_full}, 32'h1);
        chk("dir_ptr", {29'b0, ptr}, 32'h0);
        chk("dir_o5", o5, 32'h6);

        // back-pressure on channel 3, then an ack on channel 3 lets the write through
        for (int k = 0; k < 3; k++) step(1'b1, 3'd3, 1'b0, 32'hDEAD, 8'h00);
        chk("bp_o3_held", o3, 32'h4);
        step(1'b1, 3'd3, 1'b0, 32'hDEAD, 8'h08);
        chk("bp_o3_written", o3, 32'hDEAD);
        chk("bp_o_valid", {24'b0, o_valid}, 32'hFF);

        // ack alone on channels 0 and 7
        step(1'b0, 3'd0, 1'b0, 32'h0, 8'h81);
        chk("ack_o_valid", {24'b0, o_valid}, 32'h7E);
        chk("ack_o0_kept", o0, 32'h1);
        chk("ack_o7_kept", o7, 32'h8);

        // sequential wrap: 9 accepts, each channel acked one cycle after it fills
        do_reset();
        for (int k = 0; k < 9; k++)
            step(1'b1, 3'd0, 1'b1, 32'(10 + k), (k > 0) ? (8'd1 << ((k - 1) % 8)) : 8'h00);
        chk("seq_o0", o0, 32'd18);
        chk("seq_o1", o1, 32'd11);
        chk("seq_o7", o7, 32'd17);
        chk("seq_ptr", {29'b0, ptr}, 32'h1);

        // asynchronous reset mid-operation at ptr = 5
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1, 3'd0, 1'b1, 32'(100 + k), 8'h00);
        chk("mid_ptr", {29'b0, ptr}, 32'h5);
        chk("mid_o_valid", {24'b0, o_valid}, 32'h1F);
        i_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_cleared("mid_reset");
        #1 rst = 1'b0;
        model_reset();
        step(1'b1, 3'd6, 1'b1, 32'h55, 8'h00);
        chk("mid_first_o0", o0, 32'h55);

        // randomized traffic; a refused offer is held unchanged until it is accepted
        hold = 1'b0; iv = 1'b0; hd = '0; hs = '0; hq = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!hold) begin
                iv = ($urandom_range(0, 3) != 0);
                hd = $urandom;
                hs = 3'($urandom_range(0, 7));
                hq = 1'($urandom_range(0, 1));
            end
            step(iv, hs, hq, hd, 8'($urandom & $urandom));
            hold = iv && !last_acc;
        end

        chk("exp_q_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
